// File: rtl/spi_cmd_sequencer_if.sv
// System-bus side of the SPI command sequencer: one outstanding req/done transaction.
interface spi_cmd_sequencer_if #(
    parameter int ADDR_WIDTH = 17
);
    logic [ADDR_WIDTH-1:0] bus_addr_o;
    logic [7:0]            bus_data_o;
    logic                  bus_we_o;
    logic                  bus_req_o;
    logic [7:0]            bus_data_i;
    logic                  bus_done_i;

    modport master (
        output bus_addr_o, bus_data_o, bus_we_o, bus_req_o,
        input  bus_data_i, bus_done_i
    );

    modport slave (
        input  bus_addr_o, bus_data_o, bus_we_o, bus_req_o,
        output bus_data_i, bus_done_i
    );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// Decodes 1-4 byte SPI command frames into single system-bus reads/writes;
// read data is returned through spi_tx_byte_o for the host's next byte.
module spi_cmd_sequencer #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                 clk_sys_i,
    input  logic                 reset_ni,
    input  logic                 spi_cs_ni,
    input  logic [7:0]           spi_rx_byte_i,
    input  logic                 spi_rx_valid_i,
    output logic [7:0]           spi_tx_byte_o,
    output logic                 overrun_o,
    spi_cmd_sequencer_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_BUS} state_t;

    state_t state_q, state_d;

    // [1:0] form the 2-FF synchronizer, [2] is the previous synchronized value
    logic [2:0] vld_pipe;
    logic [2:0] cs_pipe;
    logic       strobe, cs_hi, cs_fall;

    logic                  cmd_rd_q, cmd_a16_q;
    logic [7:0]            hi_q;
    logic [ADDR_WIDTH-1:0] pend_q, addr_q, lo_addr, addr_commit;
    logic [7:0]            data_q, tx_q;
    logic                  we_q, req_q, ovr_q;

    logic fr_ok, take_cmd, take_hi, take_lo, take_data, enter_bus;
    logic we_d, req_d, ovr_set;

    always_ff @(posedge clk_sys_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vld_pipe <= '0;
            cs_pipe  <= '1;
        end else begin
            vld_pipe <= {vld_pipe[1:0], spi_rx_valid_i};
            cs_pipe  <= {cs_pipe[1:0], spi_cs_ni};
        end
    end

    assign strobe  = vld_pipe[1] & ~vld_pipe[2];
    assign cs_hi   = cs_pipe[1];
    assign cs_fall = ~cs_pipe[1] & cs_pipe[2];
    assign lo_addr = ADDR_WIDTH'({cmd_a16_q, hi_q, spi_rx_byte_i});

    always_ff @(posedge clk_sys_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_fall && state_q != S_BUS) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (strobe && !cs_hi)
                               state_d = spi_rx_byte_i[6] ? (spi_rx_byte_i[7] ? S_BUS : S_DATA)
                                                          : S_ADDR_HI;
                S_ADDR_HI: if (cs_hi) state_d = S_IDLE;
                           else if (strobe) state_d = S_ADDR_LO;
                S_ADDR_LO: if (cs_hi) state_d = S_IDLE;
                           else if (strobe) state_d = cmd_rd_q ? S_BUS : S_DATA;
                S_DATA:    if (cs_hi) state_d = S_IDLE;
                           else if (strobe) state_d = S_BUS;
                S_BUS:     if (bus.bus_done_i) state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Frame address is staged in pend_q and only committed on entry to BUS,
    // so an aborted frame leaves the bus address untouched.
    always_comb begin
        fr_ok       = strobe & ~cs_hi & ~cs_fall;
        take_cmd    = fr_ok && state_q == S_IDLE;
        take_hi     = fr_ok && state_q == S_ADDR_HI;
        take_lo     = fr_ok && state_q == S_ADDR_LO;
        take_data   = fr_ok && state_q == S_DATA;
        enter_bus   = (state_q != S_BUS) && (state_d == S_BUS);
        addr_commit = pend_q;
        we_d        = ~cmd_rd_q;
        if (take_cmd) begin
            addr_commit = addr_q + ADDR_WIDTH'(1);
            we_d        = ~spi_rx_byte_i[7];
        end else if (take_lo) begin
            addr_commit = lo_addr;
        end
        req_d   = (state_d == S_BUS);
        ovr_set = strobe && state_q == S_BUS;
    end

    always_ff @(posedge clk_sys_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cmd_rd_q  <= 1'b0;
            cmd_a16_q <= 1'b0;
            hi_q      <= '0;
            pend_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            req_q     <= 1'b0;
            tx_q      <= '0;
            ovr_q     <= 1'b0;
        end else begin
            if (take_cmd) begin
                cmd_rd_q  <= spi_rx_byte_i[7];
                cmd_a16_q <= spi_rx_byte_i[0];
                pend_q    <= addr_q + ADDR_WIDTH'(1);
            end
            if (take_hi)   hi_q   <= spi_rx_byte_i;
            if (take_lo)   pend_q <= lo_addr;
            if (take_data) data_q <= spi_rx_byte_i;
            if (enter_bus) begin
                addr_q <= addr_commit;
                we_q   <= we_d;
            end
            req_q <= req_d;
            if (state_q == S_BUS && bus.bus_done_i && !we_q) tx_q <= bus.bus_data_i;
            if (ovr_set)      ovr_q <= 1'b1;
            else if (cs_fall) ovr_q <= 1'b0;
        end
    end

    assign bus.bus_addr_o = addr_q;
    assign bus.bus_data_o = data_q;
    assign bus.bus_we_o   = we_q;
    assign bus.bus_req_o  = req_q;
    assign spi_tx_byte_o  = tx_q;
    assign overrun_o      = ovr_q;
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: expected bus transactions are queued
// as frames are sent; a monitor checks each request and its read-back byte.
module tb_spi_cmd_sequencer;
    logic       clk_sys_i = 1'b0;
    logic       reset_ni = 1'b0;
    logic       spi_cs_ni = 1'b1;
    logic [7:0] spi_rx_byte_i = 8'h00;
    logic       spi_rx_valid_i = 1'b0;
    logic [7:0] spi_tx_byte_o;
    logic       overrun_o;

    spi_cmd_sequencer_if #(.ADDR_WIDTH(17)) bus ();

    spi_cmd_sequencer #(.ADDR_WIDTH(17)) dut (
        .clk_sys_i     (clk_sys_i),
        .reset_ni      (reset_ni),
        .spi_cs_ni     (spi_cs_ni),
        .spi_rx_byte_i (spi_rx_byte_i),
        .spi_rx_valid_i(spi_rx_valid_i),
        .spi_tx_byte_o (spi_tx_byte_o),
        .overrun_o     (overrun_o),
        .bus           (bus)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        logic        we;
        int          hold;
        logic [7:0]  tx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_delay = 5;
    bit   auto_done = 1'b1;
    bit   hold_done = 1'b0;
    logic [7:0] rd_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [16:0] a, input logic [7:0] d, input logic we,
                        input int h, input logic [7:0] tx);
        exp_t e;
        e.addr = a; e.data = d; e.we = we; e.hold = h; e.tx = tx;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_sys_i);
        spi_rx_byte_i  = b;
        spi_rx_valid_i = 1'b1;
        repeat (4) @(negedge clk_sys_i);
        spi_rx_valid_i = 1'b0;
        repeat (4) @(negedge clk_sys_i);
    endtask

    task automatic set_cs(input logic v);
        @(negedge clk_sys_i);
        spi_cs_ni = v;
        repeat (4) @(negedge clk_sys_i);
    endtask

    task automatic wait_idle();
        repeat (2) @(negedge clk_sys_i);
        for (int i = 0; i < 200 && bus.bus_req_o; i++) @(negedge clk_sys_i);
        if (bus.bus_req_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL bus_timeout: req still 1 after 200 cycles, required 0");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"},   spi_tx_byte_o, 8'h00);
        check({tag, "_addr"}, bus.bus_addr_o, 17'h0);
        check({tag, "_data"}, bus.bus_data_o, 8'h00);
        check({tag, "_we"},   bus.bus_we_o, 1'b0);
        check({tag, "_req"},  bus.bus_req_o, 1'b0);
        check({tag, "_ovr"},  overrun_o, 1'b0);
    endtask

    // Arbiter model: done pulse done_delay cycles after req is seen
    initial begin
        int cnt;
        cnt = 0;
        bus.bus_done_i = 1'b0;
        bus.bus_data_i = 8'h00;
        forever begin
            @(negedge clk_sys_i);
            if (auto_done && bus.bus_req_o && !hold_done) begin
                cnt++;
                if (cnt >= done_delay) begin
                    bus.bus_data_i = rd_data;
                    bus.bus_done_i = 1'b1;
                    @(negedge clk_sys_i);
                    bus.bus_done_i = 1'b0;
                    bus.bus_data_i = 8'h00;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: compare each request against the scoreboard
    initial begin
        logic req_prev;
        int   hcnt;
        bit   active;
        exp_t cur;
        req_prev = 1'b0;
        hcnt = 0;
        active = 1'b0;
        forever begin
            @(negedge clk_sys_i);
            if (bus.bus_req_o && !req_prev) begin
                hcnt = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    active = 1'b0;
                    $display("FAIL unexpected_req: got req at addr 0x%0h, required no request",
                             bus.bus_addr_o);
                end else begin
                    cur = exp_q.pop_front();
                    check("bus_addr", bus.bus_addr_o, cur.addr);
                    check("bus_data", bus.bus_data_o, cur.data);
                    check("bus_we",   bus.bus_we_o,   cur.we);
                    active = 1'b1;
                end
            end
            if (bus.bus_req_o) hcnt++;
            if (!bus.bus_req_o && req_prev && active) begin
                if (cur.hold >= 0) check("req_hold", hcnt, cur.hold);
                if (!cur.we) check("tx_byte", spi_tx_byte_o, cur.tx);
                active = 1'b0;
            end
            req_prev = bus.bus_req_o;
        end
    end

    initial begin
        repeat (3) @(negedge clk_sys_i);
        reset_ni = 1'b1;
        repeat (2) @(negedge clk_sys_i);
        check_reset_outputs("por");
        set_cs(1'b0);

        // at-read 0x11234
        rd_data = 8'hA5;
        push(17'h11234, 8'h00, 1'b0, 5, 8'hA5);
        send_byte(8'h81); send_byte(8'h12); send_byte(8'h34);
        wait_idle();

        // at-write 0x08000
        push(17'h08000, 8'h5A, 1'b1, 5, 8'h00);
        send_byte(8'h00); send_byte(8'h80); send_byte(8'h00); send_byte(8'h5A);
        wait_idle();

        // reset while in ADDR_LO, then a fresh frame must decode from IDLE
        send_byte(8'h00); send_byte(8'h55);
        @(negedge clk_sys_i);
        reset_ni = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk_sys_i);
        reset_ni = 1'b1;
        repeat (4) @(negedge clk_sys_i);
        push(17'h08000, 8'h5A, 1'b1, 5, 8'h00);
        send_byte(8'h00); send_byte(8'h80); send_byte(8'h00); send_byte(8'h5A);
        wait_idle();

        // next chain wrapping 0x1FFFF -> 0x00000 -> 0x00001
        push(17'h1FFFF, 8'h11, 1'b1, 5, 8'h00);
        send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h11);
        wait_idle();
        push(17'h00000, 8'h22, 1'b1, 5, 8'h00);
        send_byte(8'h40); send_byte(8'h22);
        wait_idle();
        rd_data = 8'h6B;
        push(17'h00001, 8'h22, 1'b0, 5, 8'h6B);
        send_byte(8'hC0);
        wait_idle();

        // abort mid-frame: no request, address kept
        send_byte(8'h00); send_byte(8'h12);
        set_cs(1'b1);
        set_cs(1'b0);
        rd_data = 8'hD4;
        push(17'h00002, 8'h22, 1'b0, 5, 8'hD4);
        send_byte(8'hC0);
        wait_idle();

        // overrun while done is withheld
        hold_done = 1'b1;
        rd_data = 8'h5E;
        push(17'h10010, 8'h22, 1'b0, -1, 8'h5E);
        send_byte(8'h81); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h99);
        check("ovr_set", overrun_o, 1'b1);
        check("req_pending", bus.bus_req_o, 1'b1);
        hold_done = 1'b0;
        wait_idle();
        set_cs(1'b1);
        check("ovr_sticky", overrun_o, 1'b1);
        set_cs(1'b0);
        check("ovr_cleared", overrun_o, 1'b0);
        rd_data = 8'hE1;
        push(17'h10011, 8'h22, 1'b0, 5, 8'hE1);
        send_byte(8'hC0);
        wait_idle();

        // strobe coincident with done: byte dropped, read data still returned
        auto_done = 1'b0;
        push(17'h10100, 8'h22, 1'b0, -1, 8'h3C);
        send_byte(8'h81); send_byte(8'h01); send_byte(8'h00);
        @(negedge clk_sys_i);
        spi_rx_byte_i  = 8'h77;
        spi_rx_valid_i = 1'b1;
        @(negedge clk_sys_i);
        @(negedge clk_sys_i);
        bus.bus_data_i = 8'h3C;
        bus.bus_done_i = 1'b1;
        @(negedge clk_sys_i);
        bus.bus_done_i = 1'b0;
        bus.bus_data_i = 8'h00;
        repeat (2) @(negedge clk_sys_i);
        spi_rx_valid_i = 1'b0;
        repeat (4) @(negedge clk_sys_i);
        check("ovr_coincident", overrun_o, 1'b1);
        check("req_after_coincident", bus.bus_req_o, 1'b0);
        auto_done = 1'b1;
        set_cs(1'b1);
        set_cs(1'b0);
        rd_data = 8'h2B;
        push(17'h10101, 8'h22, 1'b0, 5, 8'h2B);
        send_byte(8'hC0);
        wait_idle();

        repeat (5) @(negedge clk_sys_i);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Sequences the SPI peripheral byte stream into PET system-bus transactions. Sits between the SPI byte shifter (SCK domain) and the system bus arbiter (clk_sys domain). Synchronizes byte-valid and chip-select, decodes a 1–4 byte command frame, issues one bus read or write with a req/done handshake, and returns read data to the shifter's transmit byte for the host's next byte.

## Interface
- ADDR_WIDTH, 17, bus address width; address wraps modulo 2^ADDR_WIDTH.
- clk_sys_i  in  1  system clock; all outputs registered on rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- spi_cs_ni  in  1  SPI chip select, async; active low; frames a command.
- spi_rx_byte_i  in  8  received byte from shifter; stable while spi_rx_valid_i high.
- spi_rx_valid_i  in  1  async level from shifter; rising edge = new byte.
- spi_tx_byte_o  out  8  byte the shifter sends on the host's next byte.
- bus_addr_o  out  ADDR_WIDTH  transaction address.
- bus_data_o  out  8  write data.
- bus_we_o  out  1  1 = write, 0 = read.
- bus_req_o  out  1  request; held until bus_done_i.
- bus_data_i  in  8  read data; valid in the cycle bus_done_i is high.
- bus_done_i  in  1  one-cycle completion pulse from arbiter.
- overrun_o  out  1  sticky: byte arrived while a bus cycle was pending.

## Operation
- Sync: spi_cs_ni and spi_rx_valid_i each pass through 2-FF synchronizers. Byte strobe = synchronized valid 0→1; spi_rx_byte_i sampled in the strobe cycle. cs_fall = synchronized cs 1→0.
- Command byte: [7] = 1 read / 0 write; [6] = 1 "next" (use addr+1, no address bytes) / 0 "at" (address bytes follow); [5:1] reserved, ignored; [0] = A16.
- Frame: at-write = cmd, hi, lo, data. at-read = cmd, hi, lo. next-write = cmd, data. next-read = cmd.
- States: IDLE → (strobe) latch cmd; at → ADDR_HI; next-write → DATA; next-read → BUS with addr incremented.
- ADDR_HI → (strobe) addr[15:8]=byte, addr[16]=cmd[0] → ADDR_LO.
- ADDR_LO → (strobe) addr[7:0]=byte → DATA if write, BUS if read.
- DATA → (strobe) bus_data_o=byte → BUS.
- BUS: bus_req_o=1 until bus_done_i; on done: req deasserts next edge; read loads spi_tx_byte_o=bus_data_i; → IDLE.
- Next: addr = addr+1 modulo 2^ADDR_WIDTH (0x1FFFF → 0x00000); cmd[0] ignored. Address register persists across frames and chip-select cycles.
- Strobe in BUS: byte dropped, overrun_o set. Strobe coincident with done is also dropped.
- cs_fall: clears overrun_o; state forced to IDLE unless in BUS.
- Synchronized cs high mid-frame (ADDR_HI/ADDR_LO/DATA): abort to IDLE, no bus cycle, address unchanged. In BUS: cycle completes normally, then IDLE.
- Reset values: spi_tx_byte_o=0x00, bus_addr_o=0, bus_data_o=0x00, bus_we_o=0, bus_req_o=0, overrun_o=0, state IDLE.

## Timing
- Strobe detected 3 clk_sys edges after spi_rx_valid_i rises (2 sync + edge detect).
- bus_req_o asserts the edge after the frame's final strobe; bus_addr_o, bus_data_o, bus_we_o valid in that same cycle and stable until done.
- bus_done_i sampled high at edge N: bus_req_o low after edge N; spi_tx_byte_o updated at edge N (reads); next command byte accepted from edge N+1.
- Host must leave ≥ 1 SPI byte time after a read command before reading the result; clk_sys ≥ 4× SCK.
- Back-to-back strobes need ≥ 1 clk_sys between them; strobes are not queued.

## Test plan
- Reset: assert reset_ni low mid-ADDR_LO → all outputs at reset values, state IDLE; deassert, send 0x00,0x80,0x00,0x5A → one write, addr 0x08000, data 0x5A, we=1.
- At-read: send 0x81,0x12,0x34; bus returns 0xA5 with done after 5 cycles → addr 0x11234, we=0, req held 5 cycles, spi_tx_byte_o=0xA5.
- Next sequence: at-write 0x01,0xFF,0xFF,0x11 then next-write 0x40,0x22 then next-read 0xC0 → writes at 0x1FFFF, 0x00000; read at 0x00001.
- Abort: 0x00,0x12 then cs_ni high → no bus_req_o; following 0xC0 reads previous address+1.
- Overrun: 0x81,0x00,0x10, hold done off, send extra byte 0x99 → overrun_o=1, byte ignored; next cs fall → overrun_o=0.
- Simultaneous: strobe in the same cycle as bus_done_i → dropped, overrun_o=1, read data still loaded into spi_tx_byte_o.
